// File: rtl/arith_pkg.sv
// Shared constants for the filter-datapath arithmetic primitives.
// SAT_MAX/SAT_MIN are the clamp limits at the default width.
package arith_pkg;

   localparam int ARITH_WIDTH = 32;
   localparam int CLA_GROUP   = 4;

   localparam logic [ARITH_WIDTH-1:0] SAT_MAX = {1'b0, {(ARITH_WIDTH-1){1'b1}}};
   localparam logic [ARITH_WIDTH-1:0] SAT_MIN = {1'b1, {(ARITH_WIDTH-1){1'b0}}};

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice.
// It also exports group propagate/generate for higher-level lookahead.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       pg,
   output logic       gg
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;

   assign w_p    = a ^ b;
   assign w_g    = a & b;
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);
   assign gg     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign pg     = &w_p;
   assign w_c[4] = gg | (pg & cin);

   assign s    = w_p ^ w_c[3:0];
   assign cout = w_c[4];

endmodule

// File: rtl/adder32_reg.sv
// Registered add/subtract with optional signed saturation and status flags.
// Datapath is a ripple of cla4 groups; every output comes straight from a flop.
module adder32_reg
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             op_sub,
   input  logic             sat_en,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [WIDTH-1:0] sum,
   output logic             out_valid,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NG = WIDTH / CLA_GROUP;
   localparam logic [WIDTH-1:0] L_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] L_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] w_beff;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_final;
   logic [NG:0]      w_c;
   logic [NG-1:0]    w_pg;
   logic [NG-1:0]    w_gg;
   logic             w_ovf;
   logic             w_unused_grp;

   // Subtraction is opA + ~opB + 1: the +1 enters as the chain carry-in.
   assign w_beff = op_sub ? ~opB : opB;
   assign w_c[0] = op_sub;

   for (genvar gi = 0; gi < NG; gi++) begin : g_cla
      cla4 u_cla4 (
         .a    (opA[gi*CLA_GROUP +: CLA_GROUP]),
         .b    (w_beff[gi*CLA_GROUP +: CLA_GROUP]),
         .cin  (w_c[gi]),
         .s    (w_raw[gi*CLA_GROUP +: CLA_GROUP]),
         .cout (w_c[gi+1]),
         .pg   (w_pg[gi]),
         .gg   (w_gg[gi])
      );
   end

   assign w_unused_grp = ^{w_pg, w_gg};

   assign w_ovf   = (opA[WIDTH-1] == w_beff[WIDTH-1]) && (w_raw[WIDTH-1] != opA[WIDTH-1]);
   assign w_final = (sat_en && w_ovf) ? (opA[WIDTH-1] ? L_SAT_MIN : L_SAT_MAX) : w_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         out_valid <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else if (in_valid) begin
         sum       <= w_final;
         out_valid <= 1'b1;
         carry     <= w_c[NG];
         overflow  <= w_ovf;
         zero      <= (w_final == '0);
         negative  <= w_final[WIDTH-1];
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder32_reg.sv
// Self-checking bench for adder32_reg: directed table, hand sequences, random vs model.
module tb_adder32_reg;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, in_valid, op_sub, sat_en;
   logic [W-1:0] opA, opB, sum;
   logic         out_valid, carry, overflow, zero, negative;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic         ov;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
      logic [W-1:0] s;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         sat;
      res_t         e;
   } vec_t;

   adder32_reg #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .op_sub(op_sub), .sat_en(sat_en),
      .opA(opA), .opB(opB), .sum(sum), .out_valid(out_valid), .carry(carry),
      .overflow(overflow), .zero(zero), .negative(negative)
   );

   always #5 clk = ~clk;

   // Reference: exact signed/unsigned arithmetic in 64 bits, then clamp or truncate.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic sat);
      res_t r;
      longint sa, sb, ideal;
      longint unsigned ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      ideal = sub ? sa - sb : sa + sb;
      r.ov = 1'b1;
      r.c  = sub ? (ua >= ub) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
      r.v  = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
      if (r.v && sat) r.s = (ideal > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else            r.s = ideal[W-1:0];
      r.z = (r.s == '0);
      r.n = r.s[W-1];
      return r;
   endfunction

   function automatic res_t dut_out();
      res_t r;
      r.ov = out_valid; r.c = carry; r.v = overflow; r.z = zero; r.n = negative; r.s = sum;
      return r;
   endfunction

   task automatic chk(input string name, input res_t exp);
      res_t act;
      act = dut_out();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got ov=%0b c=%0b v=%0b z=%0b n=%0b s=%h, want ov=%0b c=%0b v=%0b z=%0b n=%0b s=%h",
                  name, act.ov, act.c, act.v, act.z, act.n, act.s,
                  exp.ov, exp.c, exp.v, exp.z, exp.n, exp.s);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub, input logic sat);
      rst = r; in_valid = v; opA = a; opB = b; op_sub = sub; sat_en = sat;
   endtask

   vec_t  tbl [8];
   res_t  exp_st;
   res_t  zero_st;
   logic [W-1:0] edges [6];

   initial begin
      zero_st = '0;
      tbl[0] = '{32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0004}};
      tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h0000_0000}};
      tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{1'b1,1'b0,1'b1,1'b0,1'b1,32'h8000_0000}};
      tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h7FFF_FFFF}};
      tbl[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, '{1'b1,1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFE}};
      tbl[5] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_0002}};
      tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, '{1'b1,1'b1,1'b1,1'b0,1'b1,32'h8000_0000}};
      tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h0000_0000}};
      edges = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001};

      // Reset held 2 cycles with a valid op presented; nothing must leak through.
      drive(1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      step();
      chk("reset_c1", zero_st);
      step();
      chk("reset_c2", zero_st);

      // Directed table, issued back-to-back.
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sat);
         step();
         chk($sformatf("tbl%0d", i), tbl[i].e);
      end

      // Idle cycle: out_valid drops, result and flags hold.
      drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
      step();
      chk("hold", '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_0000});

      // Three consecutive ops, then reset mid-stream with a valid op that must vanish.
      drive(1'b0, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
      step();
      chk("b2b_1", '{1'b1,1'b0,1'b0,1'b0,1'b0,32'd30});
      drive(1'b0, 1'b1, 32'd100, 32'd1, 1'b1, 1'b0);
      step();
      chk("b2b_2", '{1'b1,1'b1,1'b0,1'b0,1'b0,32'd99});
      drive(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0);
      step();
      chk("b2b_3", '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_0010});
      drive(1'b1, 1'b1, 32'd7, 32'd8, 1'b0, 1'b0);
      step();
      chk("rst_mid", zero_st);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      step();
      chk("rst_drop", zero_st);

      // Random traffic against the model, with idles and occasional resets.
      exp_st = zero_st;
      for (int i = 0; i < 400; i++) begin
         logic r, v, sb, st;
         logic [W-1:0] a, b;
         r  = ($urandom_range(0, 31) == 0);
         v  = ($urandom_range(0, 3) != 0);
         sb = 1'($urandom_range(0, 1));
         st = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         drive(r, v, a, b, sb, st);
         if (r)      exp_st = zero_st;
         else if (v) exp_st = model(a, b, sb, st);
         else        exp_st.ov = 1'b0;
         step();
         chk($sformatf("rand%0d", i), exp_st);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder32_reg.md
Name: adder32_reg

Overview:
- Registered two-operand integer adder/subtractor used as the arithmetic primitive of the filter datapath.
- Takes two WIDTH-bit operands (opA, opB) plus a mode select and produces a registered sum and status flags one clock after a valid input.
- Supports wrap-around or signed-saturating results.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 4 and a multiple of 4).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands and mode are valid this cycle.
op_sub  input  1  0 = opA + opB; 1 = opA - opB.
sat_en  input  1  1 = signed saturation on overflow; 0 = wrap-around.
opA  input  WIDTH  first operand.
opB  input  WIDTH  second operand.
sum  output  WIDTH  registered result.
out_valid  output  1  sum/flags valid this cycle.
carry  output  1  carry out of MSB of the internal addition.
overflow  output  1  signed overflow of the unsaturated result.
zero  output  1  final sum == 0.
negative  output  1  MSB of final sum.

Behaviour:
- One clock; reset is synchronous and active-high.
  - Ports are clk and rst.
  - All state updates occur on the rising edge of clk.
- Reset: when rst=1 at a rising edge, sum=0, carry=0, overflow=0, zero=0, negative=0, out_valid=0.
  - rst has priority over in_valid.
  - A transaction presented in the same cycle as rst is dropped.
- Latency: exactly 1 cycle.
  - Inputs sampled at edge N with in_valid=1 give results and out_valid=1 after edge N.
  - Fully pipelined: a new operation can be accepted every cycle.
  - There is no backpressure.
- in_valid=0 at an edge: out_valid=0; sum and flags hold their previous values.
- Arithmetic:
  - Internal result is R = opA + (op_sub ? ~opB : opB) + op_sub, computed at WIDTH+1 bits.
  - carry = R[WIDTH]. For subtraction, carry=1 means no borrow (opA >= opB unsigned).
  - Raw result = R[WIDTH-1:0].
  - overflow = (opA[MSB] == Beff[MSB]) && (raw[MSB] != opA[MSB]), where Beff is the effective second operand.
- Saturation:
  - If sat_en=1 and overflow=1, sum = max positive (0x7FFF_FFFF for WIDTH=32) when opA[MSB]=0, else min negative (0x8000_0000).
  - Otherwise sum = raw.
  - overflow always reports the unsaturated condition.
- zero and negative are computed from the final (possibly saturated) sum.
- Operands are treated as two's complement for overflow and saturation only; the carry flag has unsigned meaning.
- Datapath is a ripple of 4-bit carry-lookahead groups: WIDTH/4 instances, with the group carry chained.
- No combinational path from inputs to outputs; all outputs come straight from flops.

Decomposition:
- Shared package arith_pkg:
  - WIDTH default constant
  - localparams SAT_MAX and SAT_MIN, derived per width
  - constant CLA_GROUP = 4
- One sub-module: cla4, a 4-bit carry-lookahead adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout, plus group propagate and generate.
  - Instantiated WIDTH/4 times by a generate loop in adder32_reg.

Test Plan:
- Basic add: rst high 2 cycles, then opA=1, opB=3, op_sub=0, in_valid=1 -> next cycle sum=4, out_valid=1, carry=0, overflow=0, zero=0, negative=0.
- Unsigned wrap: opA=0xFFFF_FFFF, opB=1, add -> sum=0, carry=1, zero=1, overflow=0.
- Signed overflow: opA=0x7FFF_FFFF, opB=1, add.
  - sat_en=0 -> sum=0x8000_0000, overflow=1, negative=1.
  - sat_en=1 -> sum=0x7FFF_FFFF, overflow=1, negative=0.
- Subtract: opA=3, opB=5, op_sub=1 -> sum=0xFFFF_FFFE, carry=0, negative=1. Then opA=5, opB=3 -> sum=2, carry=1.
- Negative saturation: opA=0x8000_0000, opB=1, op_sub=1, sat_en=1 -> sum=0x8000_0000, overflow=1.
- Back-to-back and reset: three consecutive valid ops -> three consecutive out_valid results in order. Assert rst with in_valid=1 mid-stream -> next cycle out_valid=0, sum=0, and that operation is never output.
